// File: rtl/brightness_fader.sv
// Encoder-driven brightness target with a rate-limited 1-LSB ramp of the applied PWM value.
// Each applied-value change is announced by a single-cycle set strobe aligned with the new value.
module brightness_fader #(
    parameter int PWM_VALUE_SIZE = 8,
    parameter int BRIGHTNESS_INC = 5,
    parameter int RAMP_DIV       = 1000
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      inc_i,
    input  logic                      dec_i,
    output logic [PWM_VALUE_SIZE-1:0] target_o,
    output logic [PWM_VALUE_SIZE-1:0] value_o,
    output logic                      set_o,
    output logic                      busy_o
);

    localparam int N     = PWM_VALUE_SIZE;
    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [N:0]       MAX_EXT  = {1'b0, {N{1'b1}}};
    localparam logic [N:0]       INC_EXT  = (N+1)'(BRIGHTNESS_INC);
    localparam logic [N-1:0]     ONE      = N'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

    logic [N-1:0]     r_target;
    logic [N-1:0]     r_value;
    logic [CNT_W-1:0] r_cnt;
    logic             r_set;

    logic [N-1:0]     w_target_nxt;
    ramp_state_t      w_state;
    logic             w_step_due;
    logic             w_step_up;
    logic             w_step_dn;

    // Sum/difference carried at N+1 bits so overflow and borrow are visible before clamping.
    function automatic logic [N-1:0] sat_add(input logic [N-1:0] a);
        logic [N:0] s;
        s = {1'b0, a} + INC_EXT;
        return (s > MAX_EXT) ? MAX_EXT[N-1:0] : s[N-1:0];
    endfunction

    function automatic logic [N-1:0] sat_sub(input logic [N-1:0] a);
        logic [N:0] s;
        s = {1'b0, a} - INC_EXT;
        return s[N] ? '0 : s[N-1:0];
    endfunction

    always_comb begin
        w_target_nxt = r_target;
        if (inc_i && !dec_i) begin
            w_target_nxt = sat_add(r_target);
        end else if (dec_i && !inc_i) begin
            w_target_nxt = sat_sub(r_target);
        end
    end

    // Pacing follows the registered compare; the step direction looks at the target being
    // written this edge so a same-cycle reversal or landing can never push value past it.
    always_comb begin
        w_state = IDLE;
        if (r_value < r_target) begin
            w_state = UP;
        end else if (r_value > r_target) begin
            w_state = DOWN;
        end
        w_step_due = (w_state != IDLE) && (r_cnt == CNT_LAST);
        w_step_up  = w_step_due && (w_target_nxt > r_value);
        w_step_dn  = w_step_due && (w_target_nxt < r_value);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_target <= '0;
            r_value  <= '0;
            r_cnt    <= '0;
            r_set    <= 1'b0;
        end else begin
            r_target <= w_target_nxt;
            r_set    <= w_step_up || w_step_dn;

            if (w_state == IDLE || w_step_due) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            if (w_step_up) begin
                r_value <= r_value + ONE;
            end else if (w_step_dn) begin
                r_value <= r_value - ONE;
            end
        end
    end

    assign target_o = r_target;
    assign value_o  = r_value;
    assign set_o    = r_set;
    assign busy_o   = (r_value != r_target);

endmodule
